// File: rtl/line_fetch_ctrl.sv
// line_fetch_ctrl: fetches each display line from the frame buffer into the off-screen half of a line buffer pair.
// Define LINE_FETCH_STATS_EN to add the fetch_cnt/miss_cnt statistics outputs.
module line_fetch_ctrl #(
    parameter int H_ACTIVE_PIXEL = 1280,
    parameter int H_TOTAL        = 1650,
    parameter int H_WIDTH        = 11,
    parameter int V_ACTIVE_LINE  = 720,
    parameter int V_TOTAL        = 750,
    parameter int V_WIDTH        = 10,
    parameter int ADDR_WIDTH     = 32,
    parameter int LINE_STRIDE    = 5120,
    parameter int LINE_BYTES     = 5120
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [H_WIDTH-1:0]    h_cnt,
    input  logic [V_WIDTH-1:0]    v_cnt,
    input  logic [ADDR_WIDTH-1:0] fb_base,
    output logic                  rd_req,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [15:0]           rd_len,
    input  logic                  rd_ack,
    input  logic                  rd_done,
    output logic                  buf_sel,
    output logic                  line_ready,
    output logic                  underflow,
`ifdef LINE_FETCH_STATS_EN
    output logic [15:0]           fetch_cnt,
    output logic [15:0]           miss_cnt,
`endif
    input  logic                  underflow_clr
);
    // The trigger must fall inside the line; clamp guards against a degenerate timing setup.
    localparam int TRIG_H = (H_ACTIVE_PIXEL < H_TOTAL) ? H_ACTIVE_PIXEL : H_TOTAL - 1;

    typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;

    state_t                state, state_n;
    logic [ADDR_WIDTH-1:0] line_addr, line_addr_n;
    logic                  line0, trig, line_start, done_evt, uf_set;

    assign line0       = v_cnt == V_WIDTH'(V_TOTAL - 1);
    assign trig        = h_cnt == H_WIDTH'(TRIG_H) && (line0 || v_cnt < V_WIDTH'(V_ACTIVE_LINE - 1));
    assign line_start  = h_cnt == '0 && v_cnt < V_WIDTH'(V_ACTIVE_LINE);
    assign done_evt    = state == XFER && rd_done;
    assign uf_set      = (trig && state != IDLE) || (line_start && !line_ready);
    assign line_addr_n = line0 ? fb_base : line_addr + ADDR_WIDTH'(LINE_STRIDE);
    assign rd_req      = state == REQ;

    always_comb begin
        state_n = state;
        if (state == IDLE && trig)
            state_n = REQ;
        else if (state == REQ && rd_ack)
            state_n = XFER;
        else if (done_evt)
            state_n = IDLE;
    end

    // line_addr tracks every trigger so a dropped fetch still advances the address sequence.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            line_addr  <= '0;
            rd_addr    <= '0;
            rd_len     <= '0;
            buf_sel    <= 1'b0;
            line_ready <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            state <= state_n;
            if (trig)
                line_addr <= line_addr_n;
            if (trig && state == IDLE) begin
                rd_addr <= line_addr_n;
                rd_len  <= 16'(LINE_BYTES);
            end
            if (line_start && line_ready)
                buf_sel <= ~buf_sel;
            line_ready <= done_evt | (line_ready & ~line_start);
            underflow  <= uf_set | (underflow & ~underflow_clr);
        end
    end

`ifdef LINE_FETCH_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_cnt <= '0;
            miss_cnt  <= '0;
        end else begin
            fetch_cnt <= underflow_clr ? '0 : (done_evt && fetch_cnt != 16'hFFFF) ? fetch_cnt + 16'd1 : fetch_cnt;
            miss_cnt  <= underflow_clr ? '0 : (uf_set && miss_cnt != 16'hFFFF) ? miss_cnt + 16'd1 : miss_cnt;
        end
    end
`endif
endmodule

// File: tb/tb_line_fetch_ctrl.sv
// tb_line_fetch_ctrl: scoreboard bench for line_fetch_ctrl on a 12x6 toy raster; expected fetch addresses are queued at
// each trigger and compared when rd_req rises. Statistics checks are built when LINE_FETCH_STATS_EN is defined.
`timescale 1ns/1ps
module tb_line_fetch_ctrl;
    localparam int LB = 64;

    logic        clk = 1'b0, rst = 1'b1;
    logic [3:0]  h_cnt = '0;
    logic [2:0]  v_cnt = '0;
    logic [31:0] fb_base = 32'h1000;
    logic        rd_req, rd_ack = 1'b0, rd_done = 1'b0;
    logic [31:0] rd_addr;
    logic [15:0] rd_len;
    logic        buf_sel, line_ready, underflow, underflow_clr = 1'b0;
`ifdef LINE_FETCH_STATS_EN
    logic [15:0] fetch_cnt, miss_cnt;
`endif

    line_fetch_ctrl #(
        .H_ACTIVE_PIXEL(8), .H_TOTAL(12), .H_WIDTH(4),
        .V_ACTIVE_LINE(4), .V_TOTAL(6), .V_WIDTH(3),
        .ADDR_WIDTH(32), .LINE_STRIDE(16), .LINE_BYTES(LB)
    ) dut (
        .clk(clk), .rst(rst), .h_cnt(h_cnt), .v_cnt(v_cnt), .fb_base(fb_base),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len), .rd_ack(rd_ack), .rd_done(rd_done),
        .buf_sel(buf_sel), .line_ready(line_ready), .underflow(underflow),
`ifdef LINE_FETCH_STATS_EN
        .fetch_cnt(fetch_cnt), .miss_cnt(miss_cnt),
`endif
        .underflow_clr(underflow_clr)
    );

    always #5 clk = ~clk;

    int          n_chk = 0, n_err = 0;
    logic [31:0] exp_q[$];
    logic [31:0] m_addr, cur_exp;
    int          rs, acnt, dcnt, ack_dly, done_dly, tog, pops;
    bit          hold, p_req, p_buf, lat_pend;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, expv);
        end
    endtask

    // One pixel clock: observe what the last edge produced, then drive the next timing position and memory responses.
    task automatic step();
        @(posedge clk);
        #1;
        if (lat_pend)
            check("lat", rd_req, 1);
        lat_pend = 0;
        if (rs == 1 && rd_ack) begin
            check("req_fall", rd_req, 0);
            rs = 2;
            dcnt = 0;
        end else if (rs == 2 && rd_done)
            rs = 0;
        if (rd_req && !p_req) begin
            check("sb_pend", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                cur_exp = exp_q.pop_front();
                pops++;
                check("rd_addr", rd_addr, cur_exp);
                check("rd_len", rd_len, LB);
            end
        end else if (rd_req) begin
            check("addr_hold", rd_addr, cur_exp);
            check("len_hold", rd_len, LB);
        end
        if (buf_sel !== p_buf)
            tog++;
        p_buf = buf_sel;
        p_req = rd_req;
        h_cnt = (h_cnt == 4'd11) ? 4'd0 : h_cnt + 4'd1;
        if (h_cnt == 4'd0)
            v_cnt = (v_cnt == 3'd5) ? 3'd0 : v_cnt + 3'd1;
        if (h_cnt == 4'd8 && (v_cnt == 3'd5 || v_cnt < 3'd3)) begin
            m_addr = (v_cnt == 3'd5) ? fb_base : m_addr + 32'd16;
            if (rs == 0) begin
                exp_q.push_back(m_addr);
                rs = 1;
                acnt = 0;
                lat_pend = 1;
            end
        end
        rd_ack = rs == 1 && rd_req && acnt >= ack_dly;
        if (rs == 1 && rd_req)
            acnt++;
        if (rs == 2)
            dcnt++;
        rd_done = rs == 2 && dcnt >= done_dly && !hold;
    endtask

    task automatic do_reset(input logic [2:0] v0);
        rst = 1'b0;
        rd_ack = 1'b0;
        rd_done = 1'b0;
        underflow_clr = 1'b0;
        h_cnt = '0;
        v_cnt = v0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req", rd_req, 0);
        check("rst_addr", rd_addr, 0);
        check("rst_len", rd_len, 0);
        check("rst_buf", buf_sel, 0);
        check("rst_ready", line_ready, 0);
        check("rst_uf", underflow, 0);
`ifdef LINE_FETCH_STATS_EN
        check("rst_fetch", fetch_cnt, 0);
        check("rst_miss", miss_cnt, 0);
`endif
        rst = 1'b1;
        exp_q.delete();
        {rs, acnt, dcnt, ack_dly, tog, pops} = '0;
        done_dly = 2;
        {hold, p_req, p_buf, lat_pend} = '0;
        m_addr = '0;
    endtask

    initial begin
        #2;
        // Clean frame, then a second line 0 fetch from a new base.
        do_reset(3'd5);
        repeat (72) step();
        check("a_pops", pops, 4);
        check("a_toggles", tog, 4);
        check("a_uf", underflow, 0);
        check("a_buf", buf_sel, 0);
        check("a_last_addr", rd_addr, 32'h1030);
        fb_base = 32'h2000;
        repeat (12) step();
        check("a_wrap_pops", pops, 5);
        check("a_wrap_addr", rd_addr, 32'h2000);
        fb_base = 32'h1000;

        // Slow acknowledge: request held stable, line 0 starts before its data lands.
        do_reset(3'd5);
        ack_dly = 5;
        repeat (19) step();
        check("b_uf", underflow, 1);
        check("b_buf", buf_sel, 0);
        check("b_ready", line_ready, 1);
        underflow_clr = 1'b1;
        step();
        underflow_clr = 1'b0;
        check("b_uf_clr", underflow, 0);

        // Withheld completion: miss at line start, next trigger dropped, address skips a stride.
        do_reset(3'd5);
        hold = 1;
        repeat (14) step();
        check("c_ls_uf", underflow, 1);
        check("c_buf", buf_sel, 0);
        underflow_clr = 1'b1;
        step();
        underflow_clr = 1'b0;
        check("c_uf_clr", underflow, 0);
        repeat (7) step();
        check("c_drop_uf", underflow, 1);
        hold = 0;
        repeat (12) step();
        check("c_q_empty", exp_q.size(), 0);
        check("c_pops", pops, 2);
        check("c_skip_addr", rd_addr, 32'h1020);

        // Asynchronous reset mid-transfer, then stray handshakes.
        do_reset(3'd5);
        repeat (10) step();
        #2 rst = 1'b0;
        rd_ack = 1'b0;
        rd_done = 1'b0;
        h_cnt = '0;
        v_cnt = 3'd4;
        #1;
        check("d_req", rd_req, 0);
        check("d_addr", rd_addr, 0);
        check("d_len", rd_len, 0);
        check("d_buf", buf_sel, 0);
        check("d_ready", line_ready, 0);
        check("d_uf", underflow, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        exp_q.delete();
        {rs, acnt, dcnt} = '0;
        {p_req, p_buf, lat_pend} = '0;
        rd_done = 1'b1;
        rd_ack = 1'b1;
        step();
        step();
        check("d_stray_ready", line_ready, 0);
        check("d_stray_req", rd_req, 0);
        check("d_stray_uf", underflow, 0);

`ifdef LINE_FETCH_STATS_EN
        // One clean frame, then a single miss.
        do_reset(3'd5);
        repeat (72) step();
        hold = 1;
        repeat (15) step();
        check("e_fetch", fetch_cnt, 4);
        check("e_miss", miss_cnt, 1);
        underflow_clr = 1'b1;
        step();
        underflow_clr = 1'b0;
        check("e_fetch_clr", fetch_cnt, 0);
        check("e_miss_clr", miss_cnt, 0);
        check("e_uf_clr", underflow, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/line_fetch_ctrl.md
LINE_FETCH_CTRL -- requirements
Module: line_fetch_ctrl

Interface
REQ-001 SHALL have parameter H_ACTIVE_PIXEL, default 1280, active pixels per line.
REQ-002 SHALL have parameter H_TOTAL, default 1650, pixel clocks per line.
REQ-003 SHALL have parameter H_WIDTH, default 11, h_cnt width.
REQ-004 SHALL have parameter V_ACTIVE_LINE, default 720, active lines per frame.
REQ-005 SHALL have parameter V_TOTAL, default 750, lines per frame.
REQ-006 SHALL have parameter V_WIDTH, default 10, v_cnt width.
REQ-007 SHALL have parameter ADDR_WIDTH, default 32, memory address width.
REQ-008 SHALL have parameter LINE_STRIDE, default 5120, byte offset between consecutive lines.
REQ-009 SHALL have parameter LINE_BYTES, default 5120, bytes per line burst (fits 16 bits).
REQ-010 SHALL have ports, one clock, asynchronous active-low reset:
 clk  input  1  pixel clock, all logic on rising edge
 rst  input  1  asynchronous active-low reset
 h_cnt  input  H_WIDTH  horizontal position from timing generator
 v_cnt  input  V_WIDTH  vertical position from timing generator
 fb_base  input  ADDR_WIDTH  frame buffer base address
 rd_req  output  1  line read request
 rd_addr  output  ADDR_WIDTH  request start address
 rd_len  output  16  request length in bytes
 rd_ack  input  1  request accepted
 rd_done  input  1  burst fully written into line buffer
 buf_sel  output  1  line buffer currently displayed; fill target is ~buf_sel
 line_ready  output  1  fill buffer holds complete next line
 underflow  output  1  sticky error flag
 underflow_clr  input  1  clears underflow

Function
REQ-011 SHALL implement FSM IDLE -> REQ -> XFER -> IDLE.
REQ-012 Trigger SHALL fire when h_cnt==H_ACTIVE_PIXEL and either v_cnt==V_TOTAL-1 (target line 0) or v_cnt<V_ACTIVE_LINE-1 (target v_cnt+1).
REQ-013 Line-0 trigger SHALL latch fb_base as rd_addr; later triggers SHALL set rd_addr = previous rd_addr + LINE_STRIDE (modulo 2^ADDR_WIDTH).
REQ-014 Trigger in IDLE SHALL enter REQ next cycle with rd_req=1, rd_len=LINE_BYTES.
REQ-015 In REQ, rd_req/rd_addr/rd_len SHALL stay stable until rd_ack sampled 1; then rd_req=0 next cycle and state XFER.
REQ-016 In XFER, rd_done=1 SHALL return to IDLE and set line_ready=1 next cycle; rd_done outside XFER SHALL be ignored.
REQ-017 Trigger while not IDLE SHALL be dropped, set underflow, leave in-flight fetch untouched (address still advances by LINE_STRIDE).
REQ-018 At h_cnt==0 with v_cnt<V_ACTIVE_LINE: line_ready=1 -> toggle buf_sel, clear line_ready; line_ready=0 -> set underflow, buf_sel unchanged.
REQ-019 line_ready set (REQ-016) and line-start clear (REQ-018) same cycle: set SHALL win.
REQ-020 underflow_clr SHALL clear underflow next cycle; simultaneous set SHALL win.
REQ-021 Latency trigger -> rd_req high SHALL be exactly 1 cycle.

Reset
REQ-022 rst low SHALL asynchronously force state IDLE, rd_req=0, rd_addr=0, rd_len=0, buf_sel=0, line_ready=0, underflow=0 (stats counters 0).
REQ-023 Reset during REQ/XFER SHALL abandon the fetch; rd_ack/rd_done arriving after release SHALL be ignored until next REQ.

Configuration
REQ-024 Macro LINE_FETCH_STATS_EN defined: SHALL add outputs fetch_cnt[15:0] (increments on each rd_done accepted in XFER) and miss_cnt[15:0] (increments on each underflow set event), both saturating at 16'hFFFF, cleared by reset and underflow_clr.
REQ-025 Macro undefined: SHALL omit those ports and logic; all other behaviour identical.

Verification (H_ACTIVE_PIXEL=8, H_TOTAL=12, V_ACTIVE_LINE=4, V_TOTAL=6, LINE_STRIDE=16, fb_base=0x1000)
REQ-026 rd_ack 1 cycle after rd_req, rd_done 2 cycles later, full frame -> rd_addr 0x1000,0x1010,0x1020,0x1030; buf_sel toggles 4 times; underflow=0.
REQ-027 rd_ack held 0 for 5 cycles -> rd_req, rd_addr, rd_len stable throughout; rd_req=0 cycle after ack.
REQ-028 rd_done withheld past h_cnt==0 of line 1 -> underflow=1, buf_sel unchanged; underflow_clr pulse -> underflow=0.
REQ-029 rd_done withheld until next trigger -> trigger dropped, underflow=1, next accepted rd_addr skips one stride.
REQ-030 rst low during XFER, then stray rd_done -> all outputs at reset values, line_ready stays 0.
REQ-031 With LINE_FETCH_STATS_EN, one clean frame plus one miss -> fetch_cnt=4, miss_cnt=1; underflow_clr -> both 0.
